// File: rtl/systolic_seq_pkg.sv
// Shared types and helpers for the systolic array sequencing controller.
package tpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Cycles needed for the last skewed operand to reach the far corner cell.
    function automatic int feed_len(input int dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/systolic_seq_skew_mask.sv
// Skewed inject-valid mask: lane k is live while k <= cnt < k+DIM.
module skew_mask #(
    parameter int DIM  = 8,
    parameter int CNTW = $clog2(3 * DIM)
) (
    input  logic [CNTW-1:0] cnt,
    input  logic            active,
    output logic [DIM-1:0]  mask
);

    logic [31:0] cnt_ext;

    assign cnt_ext = 32'(cnt);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mask = '0;
        for (int k = 0; k < DIM; k++) begin
            if (active && (cnt_ext >= 32'(k)) && (cnt_ext < 32'(k + DIM))) begin
                mask[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_seq.sv
// Sequencing controller for a DIM x DIM systolic MAC array: clear, skewed feed, row readout, done.
module systolic_seq
    import tpu_pkg::*;
#(
    parameter int DIM  = 8,
    parameter int CNTW = $clog2(3 * DIM),
    parameter int ROWW = (DIM > 2) ? $clog2(DIM) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            clr_acc,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic            mac_en,
    output logic            mac_WrEn,
    output logic [CNTW-1:0] feed_cnt,
    output logic [DIM-1:0]  a_valid,
    output logic [DIM-1:0]  b_valid,
    output logic [ROWW-1:0] c_rd_row,
    output logic            c_rd_valid
);

    localparam int              FEED_LEN  = feed_len(DIM);
    localparam logic [CNTW-1:0] FEED_LAST = CNTW'(FEED_LEN - 1);
    localparam logic [ROWW-1:0] ROW_LAST  = ROWW'(DIM - 1);

    state_e          state_q, state_d;
    logic [CNTW-1:0] feed_cnt_q, feed_cnt_d;
    logic [ROWW-1:0] row_q, row_d;
    logic            stall_q, stall_d;
    logic            feed_live;

    always_comb begin
        state_d    = state_q;
        feed_cnt_d = feed_cnt_q;
        row_d      = row_q;
        // Stall is only meaningful in FEED/READ; it is registered so outputs never see it directly.
        stall_d    = stall && ((state_q == ST_FEED) || (state_q == ST_READ));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = clr_acc ? ST_CLEAR : ST_FEED;
                    feed_cnt_d = '0;
                    row_d      = '0;
                end
            end
            ST_CLEAR: state_d = ST_FEED;
            ST_FEED: begin
                if (!stall) begin
                    if (feed_cnt_q == FEED_LAST) begin
                        state_d    = ST_READ;
                        feed_cnt_d = '0;
                        row_d      = '0;
                    end else begin
                        feed_cnt_d = feed_cnt_q + CNTW'(1);
                    end
                end
            end
            ST_READ: begin
                if (!stall) begin
                    if (row_q == ROW_LAST) begin
                        state_d = ST_DONE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROWW'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            feed_cnt_q <= '0;
            row_q      <= '0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            feed_cnt_q <= feed_cnt_d;
            row_q      <= row_d;
            stall_q    <= stall_d;
        end
    end

    assign feed_live  = (state_q == ST_FEED) && !stall_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign mac_en     = (state_q == ST_CLEAR) || feed_live;
    assign mac_WrEn   = (state_q == ST_CLEAR);
    assign feed_cnt   = feed_cnt_q;
    assign c_rd_row   = row_q;
    assign c_rd_valid = (state_q == ST_READ) && !stall_q;

    skew_mask #(.DIM(DIM), .CNTW(CNTW)) u_a_mask (
        .cnt    (feed_cnt_q),
        .active (feed_live),
        .mask   (a_valid)
    );

    skew_mask #(.DIM(DIM), .CNTW(CNTW)) u_b_mask (
        .cnt    (feed_cnt_q),
        .active (feed_live),
        .mask   (b_valid)
    );

endmodule

// File: tb/tb_systolic_seq.sv
// Directed self-checking bench for systolic_seq at DIM=4 (FEED_LEN=10).
module tb_systolic_seq;

    localparam int DIM  = 4;
    localparam int CNTW = 4;
    localparam int ROWW = 2;
    localparam int FLEN = 10;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            clr_acc;
    logic            stall;
    logic            busy;
    logic            done;
    logic            mac_en;
    logic            mac_WrEn;
    logic [CNTW-1:0] feed_cnt;
    logic [DIM-1:0]  a_valid;
    logic [DIM-1:0]  b_valid;
    logic [ROWW-1:0] c_rd_row;
    logic            c_rd_valid;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Hand-derived skew masks for feed_cnt 0..9 at DIM=4.
    logic [3:0] a_tbl [FLEN] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

    systolic_seq #(.DIM(DIM), .CNTW(CNTW), .ROWW(ROWW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clr_acc    (clr_acc),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .mac_en     (mac_en),
        .mac_WrEn   (mac_WrEn),
        .feed_cnt   (feed_cnt),
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .c_rd_row   (c_rd_row),
        .c_rd_valid (c_rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // {busy, done, mac_en, mac_WrEn, feed_cnt, a_valid, b_valid, c_rd_row, c_rd_valid}
    function automatic logic [18:0] obs_vec();
        return {busy, done, mac_en, mac_WrEn, feed_cnt, a_valid, b_valid, c_rd_row, c_rd_valid};
    endfunction

    // Expected outputs k cycles after the start edge of an unstalled run.
    function automatic logic [18:0] exp_vec(input int k, input bit clr);
        int         base;
        logic       b, d, m, w, rv;
        logic [3:0] fc, av;
        logic [1:0] row;
        base = clr ? 2 : 1;
        {b, d, m, w, rv} = '0;
        fc = '0; av = '0; row = '0;
        if (clr && k == 1) begin
            b = 1'b1; m = 1'b1; w = 1'b1;
        end else if (k >= base && k < base + FLEN) begin
            b = 1'b1; m = 1'b1;
            fc = 4'(k - base);
            av = a_tbl[k - base];
        end else if (k >= base + FLEN && k < base + FLEN + DIM) begin
            b = 1'b1; rv = 1'b1;
            row = 2'(k - base - FLEN);
        end else if (k == base + FLEN + DIM) begin
            b = 1'b1; d = 1'b1;
        end
        return {b, d, m, w, fc, av, av, row, rv};
    endfunction

    task automatic run_op(input string name, input bit clr, input bit poke);
        int base;
        int dones;
        base    = clr ? 2 : 1;
        dones   = 0;
        start   = 1'b1;
        clr_acc = clr;
        tick();
        start   = 1'b0;
        clr_acc = 1'b0;
        for (int k = 1; k <= base + FLEN + DIM + 2; k++) begin
            check($sformatf("%s_k%0d", name, k), 32'(obs_vec()), 32'(exp_vec(k, clr)));
            if (done) dones++;
            start = poke && ((k == base + 3) || (k == base + FLEN + DIM));
            tick();
        end
        start = 1'b0;
        check({name, "_done_count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        int  t0;
        bit  found;

        rst_n = 1'b0; start = 1'b0; clr_acc = 1'b0; stall = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_outputs", 32'(obs_vec()), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle_%0d", i), 32'(obs_vec()), 32'd0);
        end

        run_op("clr1", 1'b1, 1'b0);
        run_op("clr0", 1'b0, 1'b0);
        run_op("busy_start", 1'b1, 1'b1);

        // Stall: 3 cycles at feed_cnt=5, then 1 cycle at read row 2.
        t0 = cyc;
        start = 1'b1; clr_acc = 1'b1;
        tick();
        start = 1'b0; clr_acc = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (busy && mac_en && !mac_WrEn && feed_cnt == 4'd5) found = 1'b1;
            else tick();
        end
        check("stall_reach_cnt5", 32'(found), 32'd1);
        check("stall_pre_a_valid", 32'(a_valid), 32'b1100);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_feed_%0d", i),
                  32'({feed_cnt, mac_en, a_valid, b_valid, busy}), 32'({4'd5, 1'b0, 4'd0, 4'd0, 1'b1}));
        end
        stall = 1'b0;
        tick();
        check("stall_feed_resume", 32'({feed_cnt, mac_en, a_valid}), 32'({4'd6, 1'b1, 4'b1000}));
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (c_rd_valid && c_rd_row == 2'd2) found = 1'b1;
            else tick();
        end
        check("stall_reach_row2", 32'(found), 32'd1);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        check("stall_read_hold", 32'({c_rd_row, c_rd_valid, mac_en, busy}), 32'({2'd2, 1'b0, 1'b0, 1'b1}));
        tick();
        check("stall_read_resume", 32'({c_rd_row, c_rd_valid}), 32'({2'd3, 1'b1}));
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done) found = 1'b1;
            else tick();
        end
        check("stall_done_seen", 32'(found), 32'd1);
        check("stall_done_latency", 32'(cyc - t0), 32'd20);
        tick();
        check("stall_back_idle", 32'(obs_vec()), 32'd0);

        // Mid-operation reset at feed_cnt=7.
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (busy && mac_en && feed_cnt == 4'd7) found = 1'b1;
            else tick();
        end
        check("midrst_reach_cnt7", 32'(found), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_outputs", 32'(obs_vec()), 32'd0);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) found = 1'b1;
        end
        check("midrst_no_done", 32'(found), 32'd0);
        run_op("after_rst", 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
